// File: rtl/pmp_region_checker_if.sv
// Bus bundle for the PMP checker: CSR port, request/response check pipe and
// sticky fault report. The core side (LSU/fetch + CSR file) is the master.
interface pmp_region_checker_if #(
  parameter int XLEN = 32
);
  // CSR port
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wdata;
  logic [31:0]     csr_rdata;
  // check request
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_type;
  logic            req_priv_m;
  // check response
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_allow;
  logic            rsp_hit;
  logic [3:0]      rsp_idx;
  // sticky fault capture
  logic            fault_valid;
  logic [XLEN-1:0] fault_addr;
  logic [1:0]      fault_type;
  logic            fault_clr;

  modport master (
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata,
    output req_valid, req_addr, req_type, req_priv_m,
    input  req_ready,
    input  rsp_valid, rsp_allow, rsp_hit, rsp_idx,
    output rsp_ready,
    input  fault_valid, fault_addr, fault_type,
    output fault_clr
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata,
    input  req_valid, req_addr, req_type, req_priv_m,
    output req_ready,
    output rsp_valid, rsp_allow, rsp_hit, rsp_idx,
    input  rsp_ready,
    output fault_valid, fault_addr, fault_type,
    input  fault_clr
  );
endinterface

// File: rtl/pmp_region_checker.sv
// Multi-entry RISC-V PMP checker. Holds NUM_ENTRIES cfg/addr pairs, matches
// each request against all of them (OFF/TOR/NA4/NAPOT, lowest index wins),
// registers the decision in a one-deep valid/ready pipe and keeps a sticky
// record of the first denied access delivered downstream.
module pmp_region_checker #(
  parameter int NUM_ENTRIES = 4,
  parameter int XLEN        = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pmp_region_checker_if.slave bus
);

  localparam int          AW        = XLEN - 2;
  localparam logic [11:0] CFG_BASE  = 12'h3A0;
  localparam logic [11:0] ADDR_BASE = 12'h3B0;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } amode_e;

  typedef struct packed {
    logic       l;
    logic [1:0] zero;
    amode_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  pmp_cfg_t               cfg_q  [NUM_ENTRIES];
  logic [AW-1:0]          addr_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] addr_locked;
  logic [NUM_ENTRIES-1:0] entry_hit;

  logic            win_hit;
  logic [3:0]      win_idx;
  logic            win_l;
  logic            win_perm;
  logic            allow;
  logic            accept;
  logic            fault_fire;
  logic [XLEN-1:0] pipe_addr;
  logic [1:0]      pipe_type;

  // Reserved bits read as zero and W without R is not a legal combination.
  function automatic pmp_cfg_t legalize_cfg(input logic [7:0] b);
    pmp_cfg_t c;
    c.l    = b[7];
    c.zero = 2'b00;
    c.a    = amode_e'(b[4:3]);
    c.x    = b[2];
    c.w    = b[1] & b[0];
    c.r    = b[0];
    return c;
  endfunction

  // CSR writes into the entry registers, honouring per-entry locks.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the entry arrays are plain flops, not RAM, so they take the reset
      // like any register; all-OFF and unlocked is the required power-up state.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
    end else if (bus.csr_we) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((bus.csr_addr == CFG_BASE + 12'(i / 4)) && !cfg_q[i].l)
          cfg_q[i] <= legalize_cfg(bus.csr_wdata[8*(i%4) +: 8]);
        if ((bus.csr_addr == ADDR_BASE + 12'(i)) && !addr_locked[i])
          addr_q[i] <= AW'(bus.csr_wdata);
      end
    end
  end

  // Combinational CSR readback; unmapped or unimplemented numbers read zero.
  // NOTE: every output of this block gets a default first, so no path through
  // it can leave a value unassigned and infer a latch.
  always_comb begin
    bus.csr_rdata = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (bus.csr_addr == CFG_BASE + 12'(i / 4))
        bus.csr_rdata[8*(i%4) +: 8] = cfg_q[i];
      if (bus.csr_addr == ADDR_BASE + 12'(i))
        bus.csr_rdata = 32'(addr_q[i]);
    end
  end

  // Per-entry address match and address-register lock.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    logic [XLEN-1:0] tor_lo;
    logic [XLEN-1:0] tor_hi;
    logic [AW-1:0]   napot_care;
    logic            tor_match;
    logic            na4_match;
    logic            napot_match;

    if (g == 0) begin : g_lo_zero
      assign tor_lo = '0;
    end else begin : g_lo_prev
      assign tor_lo = {addr_q[g-1], 2'b00};
    end

    // A locked TOR entry also freezes the address below it (its lower bound).
    if (g == NUM_ENTRIES - 1) begin : g_lock_last
      assign addr_locked[g] = cfg_q[g].l;
    end else begin : g_lock_next
      assign addr_locked[g] = cfg_q[g].l | (cfg_q[g+1].l & (cfg_q[g+1].a == A_TOR));
    end

    assign tor_hi    = {addr_q[g], 2'b00};
    assign tor_match = (tor_lo < tor_hi) && (bus.req_addr >= tor_lo) && (bus.req_addr < tor_hi);
    assign na4_match = (bus.req_addr[XLEN-1:2] == addr_q[g]);

    // Trailing ones plus the first zero of pmpaddr are don't-care bits;
    // x ^ (x+1) sets exactly those positions (all of them for all-ones).
    assign napot_care  = ~(addr_q[g] ^ (addr_q[g] + AW'(1)));
    assign napot_match = (((bus.req_addr[XLEN-1:2] ^ addr_q[g]) & napot_care) == '0);

    assign entry_hit[g] = (cfg_q[g].a == A_TOR)   ? tor_match   :
                          (cfg_q[g].a == A_NA4)   ? na4_match   :
                          (cfg_q[g].a == A_NAPOT) ? napot_match : 1'b0;
  end

  // Lowest-index hit wins; then apply permission / M-mode rules.
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = '0;
    win_l    = 1'b0;
    win_perm = 1'b0;
    allow    = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_hit[i]) begin
        win_hit = 1'b1;
        win_idx = 4'(i);
        win_l   = cfg_q[i].l;
        case (bus.req_type)
          2'b01:   win_perm = cfg_q[i].w;
          2'b10:   win_perm = cfg_q[i].x;
          default: win_perm = cfg_q[i].r;
        endcase
      end
    end
    if (!win_hit)
      allow = bus.req_priv_m;
    else if (bus.req_priv_m && !win_l)
      allow = 1'b1;
    else
      allow = win_perm;
  end

  assign bus.req_ready = !bus.rsp_valid || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // One-deep response register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_allow <= 1'b0;
      bus.rsp_hit   <= 1'b0;
      bus.rsp_idx   <= '0;
      pipe_addr     <= '0;
      pipe_type     <= '0;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_allow <= allow;
      bus.rsp_hit   <= win_hit;
      bus.rsp_idx   <= win_idx;
      pipe_addr     <= bus.req_addr;
      pipe_type     <= bus.req_type;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

  assign fault_fire = bus.rsp_valid && bus.rsp_ready && !bus.rsp_allow && !bus.fault_valid;

  // Sticky capture of the first delivered denial; a new capture beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.fault_valid <= 1'b0;
      bus.fault_addr  <= '0;
      bus.fault_type  <= '0;
    end else if (fault_fire) begin
      bus.fault_valid <= 1'b1;
      bus.fault_addr  <= pipe_addr;
      bus.fault_type  <= pipe_type;
    end else if (bus.fault_clr) begin
      bus.fault_valid <= 1'b0;
    end
  end

endmodule
